// File: rtl/ex_alu_stage_if.sv
// EX-to-MEM bus bundle for ex_alu_stage: EX-stage operands/control in, EX/MEM register out.
// Optional ovf_m member exists only when EX_OVERFLOW_TRAP_EN is defined.
interface ex_alu_stage_if #(
  parameter int WIDTH   = 32,
  parameter int REGADDR = 5
);
  logic               stall_e;
  logic               flush_m;
  logic               valid_e;
  logic [2:0]         alucontrol;
  logic [WIDTH-1:0]   srca;
  logic [WIDTH-1:0]   srcb;
  logic [WIDTH-1:0]   writedata_e;
  logic [REGADDR-1:0] writereg_e;
  logic               regwrite_e;
  logic               memtoreg_e;
  logic               memwrite_e;
  logic               branch_e;

  logic [WIDTH-1:0]   aluout_m;
  logic               zero_m;
  logic [WIDTH-1:0]   writedata_m;
  logic [REGADDR-1:0] writereg_m;
  logic               regwrite_m;
  logic               memtoreg_m;
  logic               memwrite_m;
  logic               pcsrc_m;
  logic               valid_m;
`ifdef EX_OVERFLOW_TRAP_EN
  logic               ovf_m;
`endif

  // Upstream / bench side: drives EX inputs, observes MEM outputs
  modport master (
`ifdef EX_OVERFLOW_TRAP_EN
    input  ovf_m,
`endif
    output stall_e, flush_m, valid_e, alucontrol, srca, srcb, writedata_e,
           writereg_e, regwrite_e, memtoreg_e, memwrite_e, branch_e,
    input  aluout_m, zero_m, writedata_m, writereg_m, regwrite_m,
           memtoreg_m, memwrite_m, pcsrc_m, valid_m
  );

  // Execute stage side
  modport slave (
`ifdef EX_OVERFLOW_TRAP_EN
    output ovf_m,
`endif
    input  stall_e, flush_m, valid_e, alucontrol, srca, srcb, writedata_e,
           writereg_e, regwrite_e, memtoreg_e, memwrite_e, branch_e,
    output aluout_m, zero_m, writedata_m, writereg_m, regwrite_m,
           memtoreg_m, memwrite_m, pcsrc_m, valid_m
  );
endinterface

// File: rtl/ex_alu_stage.sv
// Execute stage: combinational ALU, beq resolution, and the EX/MEM pipeline register
// with reset > flush > stall > load priority.
// Optional feature macro: EX_OVERFLOW_TRAP_EN (signed add/sub overflow flag that
// suppresses the register write of the overflowing instruction).
module ex_alu_stage #(
  parameter int WIDTH   = 32,
  parameter int REGADDR = 5
) (
  input logic           clk,
  input logic           rst,
  ex_alu_stage_if.slave bus
);

  logic [WIDTH-1:0]   sumVal;
  logic [WIDTH-1:0]   diffVal;
  logic               sltVal;
  logic [WIDTH-1:0]   aluResult;
  logic               aluZero;
  logic               wrEnable;

  logic [WIDTH-1:0]   aluout_q,    aluout_d;
  logic               zero_q,      zero_d;
  logic [WIDTH-1:0]   writedata_q, writedata_d;
  logic [REGADDR-1:0] writereg_q,  writereg_d;
  logic               regwrite_q,  regwrite_d;
  logic               memtoreg_q,  memtoreg_d;
  logic               memwrite_q,  memwrite_d;
  logic               pcsrc_q,     pcsrc_d;
  logic               valid_q,     valid_d;

  assign sumVal  = bus.srca + bus.srcb;
  assign diffVal = bus.srca - bus.srcb;
  // True signed compare; the sign of the difference is wrong when the subtraction overflows
  assign sltVal  = $signed(bus.srca) < $signed(bus.srcb);

  // ALU operation select; unused codes yield zero
  always_comb begin
    aluResult = '0;
    case (bus.alucontrol)
      3'b010:  aluResult = sumVal;
      3'b110:  aluResult = diffVal;
      3'b000:  aluResult = bus.srca & bus.srcb;
      3'b001:  aluResult = bus.srca | bus.srcb;
      3'b111:  aluResult = {{(WIDTH-1){1'b0}}, sltVal};
      default: aluResult = '0;
    endcase
  end

  assign aluZero = (aluResult == '0);

`ifdef EX_OVERFLOW_TRAP_EN
  logic addOvf;
  logic subOvf;
  logic ovfNow;
  logic ovf_q, ovf_d;

  // Add overflows when like-signed operands give a differently signed sum;
  // sub overflows when unlike-signed operands give a result whose sign differs from srca
  assign addOvf = (bus.srca[WIDTH-1] == bus.srcb[WIDTH-1]) && (sumVal[WIDTH-1] != bus.srca[WIDTH-1]);
  assign subOvf = (bus.srca[WIDTH-1] != bus.srcb[WIDTH-1]) && (diffVal[WIDTH-1] != bus.srca[WIDTH-1]);
  assign ovfNow = bus.valid_e && (((bus.alucontrol == 3'b010) && addOvf) ||
                                  ((bus.alucontrol == 3'b110) && subOvf));
  assign wrEnable = bus.regwrite_e && !ovfNow;
`else
  assign wrEnable = bus.regwrite_e;
`endif

  // Next EX/MEM contents: bubble on flush, hold on stall, otherwise capture EX with valid qualification
  always_comb begin
    aluout_d    = aluout_q;
    zero_d      = zero_q;
    writedata_d = writedata_q;
    writereg_d  = writereg_q;
    regwrite_d  = regwrite_q;
    memtoreg_d  = memtoreg_q;
    memwrite_d  = memwrite_q;
    pcsrc_d     = pcsrc_q;
    valid_d     = valid_q;
`ifdef EX_OVERFLOW_TRAP_EN
    ovf_d       = ovf_q;
`endif
    if (bus.flush_m) begin
      aluout_d    = '0;
      zero_d      = 1'b0;
      writedata_d = '0;
      writereg_d  = '0;
      regwrite_d  = 1'b0;
      memtoreg_d  = 1'b0;
      memwrite_d  = 1'b0;
      pcsrc_d     = 1'b0;
      valid_d     = 1'b0;
`ifdef EX_OVERFLOW_TRAP_EN
      ovf_d       = 1'b0;
`endif
    end else if (!bus.stall_e) begin
      aluout_d    = aluResult;
      zero_d      = aluZero;
      writedata_d = bus.writedata_e;
      writereg_d  = bus.writereg_e;
      regwrite_d  = wrEnable && bus.valid_e;
      memtoreg_d  = bus.memtoreg_e;
      memwrite_d  = bus.memwrite_e && bus.valid_e;
      pcsrc_d     = bus.branch_e && aluZero && bus.valid_e;
      valid_d     = bus.valid_e;
`ifdef EX_OVERFLOW_TRAP_EN
      ovf_d       = ovfNow;
`endif
    end
  end

  // EX/MEM register with synchronous reset that drops any in-flight instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      aluout_q    <= '0;
      zero_q      <= 1'b0;
      writedata_q <= '0;
      writereg_q  <= '0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      pcsrc_q     <= 1'b0;
      valid_q     <= 1'b0;
`ifdef EX_OVERFLOW_TRAP_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      aluout_q    <= aluout_d;
      zero_q      <= zero_d;
      writedata_q <= writedata_d;
      writereg_q  <= writereg_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      memwrite_q  <= memwrite_d;
      pcsrc_q     <= pcsrc_d;
      valid_q     <= valid_d;
`ifdef EX_OVERFLOW_TRAP_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.aluout_m    = aluout_q;
  assign bus.zero_m      = zero_q;
  assign bus.writedata_m = writedata_q;
  assign bus.writereg_m  = writereg_q;
  assign bus.regwrite_m  = regwrite_q;
  assign bus.memtoreg_m  = memtoreg_q;
  assign bus.memwrite_m  = memwrite_q;
  assign bus.pcsrc_m     = pcsrc_q;
  assign bus.valid_m     = valid_q;
`ifdef EX_OVERFLOW_TRAP_EN
  assign bus.ovf_m       = ovf_q;
`endif

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed bench for ex_alu_stage: ALU ops, beq resolution, slt edges, stall/flush/reset
// priority, invalid-slot qualification and the EX_OVERFLOW_TRAP_EN variant.
module tb_ex_alu_stage;

  logic clk;
  logic rst;
  int   total;
  int   bad;

`ifdef EX_OVERFLOW_TRAP_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  ex_alu_stage_if #(.WIDTH(32), .REGADDR(5)) bus ();

  ex_alu_stage #(.WIDTH(32), .REGADDR(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one EX-stage instruction, then advance one edge and settle before sampling
  task automatic applyStimulus(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                               input logic vld, input logic rw, input logic mw, input logic mtr,
                               input logic br, input logic [31:0] wd, input logic [4:0] wr);
    bus.alucontrol  = ctrl;
    bus.srca        = a;
    bus.srcb        = b;
    bus.valid_e     = vld;
    bus.regwrite_e  = rw;
    bus.memwrite_e  = mw;
    bus.memtoreg_e  = mtr;
    bus.branch_e    = br;
    bus.writedata_e = wd;
    bus.writereg_e  = wr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every registered MEM-side output against hand-computed values
  task automatic checkOutput(input string tag, input logic [31:0] alu, input logic zero,
                             input logic rw, input logic mw, input logic pc, input logic vld,
                             input logic mtr, input logic [31:0] wd, input logic [4:0] wr);
    checkField({tag, ".aluout"},    bus.aluout_m,            alu);
    checkField({tag, ".zero"},      {31'd0, bus.zero_m},     {31'd0, zero});
    checkField({tag, ".regwrite"},  {31'd0, bus.regwrite_m}, {31'd0, rw});
    checkField({tag, ".memwrite"},  {31'd0, bus.memwrite_m}, {31'd0, mw});
    checkField({tag, ".pcsrc"},     {31'd0, bus.pcsrc_m},    {31'd0, pc});
    checkField({tag, ".valid"},     {31'd0, bus.valid_m},    {31'd0, vld});
    checkField({tag, ".memtoreg"},  {31'd0, bus.memtoreg_m}, {31'd0, mtr});
    checkField({tag, ".writedata"}, bus.writedata_m,         wd);
    checkField({tag, ".writereg"},  {27'd0, bus.writereg_m}, {27'd0, wr});
  endtask

  task automatic checkOvf(input string tag, input logic exp);
`ifdef EX_OVERFLOW_TRAP_EN
    checkField({tag, ".ovf"}, {31'd0, bus.ovf_m}, {31'd0, exp});
`else
    if (exp) $display("[TB] %s: ovf_m absent in this build", tag);
`endif
  endtask

  // Linear directed sequence
  initial begin
    total = 0;
    bad   = 0;
    rst          = 1'b1;
    bus.stall_e  = 1'b0;
    bus.flush_m  = 1'b0;

    // Reset held for two cycles with a live instruction presented: outputs stay zero
    applyStimulus(3'b010, 32'd5, 32'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hAAAA, 5'd3);
    checkOutput("reset1", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0);
    applyStimulus(3'b010, 32'd5, 32'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hAAAA, 5'd3);
    checkOutput("reset2", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0);
    checkOvf("reset2", 1'b0);
    rst = 1'b0;

    // add 5+7
    applyStimulus(3'b010, 32'd5, 32'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1111, 5'd8);
    checkOutput("add", 32'd12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1111, 5'd8);

    // beq taken then not taken
    applyStimulus(3'b110, 32'h1234, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 5'd0);
    checkOutput("beqTaken", 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 5'd0);
    applyStimulus(3'b110, 32'h1234, 32'h1235, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 5'd0);
    checkOutput("beqNot", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0);

    // slt signed edges
    applyStimulus(3'b111, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd9);
    checkOutput("sltNeg", 32'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 5'd9);
    applyStimulus(3'b111, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd9);
    checkOutput("sltOvfEdge", 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 5'd9);

    // or, and an unused opcode that must give zero
    applyStimulus(3'b001, 32'hF0, 32'h0F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h5, 5'd4);
    checkOutput("or", 32'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h5, 5'd4);
    applyStimulus(3'b011, 32'h12, 32'h34, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h6, 5'd5);
    checkOutput("op011", 32'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h6, 5'd5);

    // and, then three stall cycles with changing inputs
    applyStimulus(3'b000, 32'hF0, 32'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEAD, 5'd7);
    checkOutput("and", 32'h30, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEAD, 5'd7);
    bus.stall_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b010, 32'd100 + 32'(i), 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBEEF, 5'd31);
      checkOutput($sformatf("stall%0d", i), 32'h30, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEAD, 5'd7);
    end

    // flush wins over stall
    bus.flush_m = 1'b1;
    applyStimulus(3'b010, 32'd1, 32'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hBEEF, 5'd31);
    checkOutput("flush", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0);
    bus.flush_m = 1'b0;
    bus.stall_e = 1'b0;

    // Invalid slot never writes or branches; data fields still load
    applyStimulus(3'b110, 32'h55, 32'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h77, 5'd2);
    checkOutput("invalid", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h77, 5'd2);

    // Signed overflow on add and sub
    applyStimulus(3'b010, 32'h7FFFFFFF, 32'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd10);
    checkOutput("addOvf", 32'h80000000, 1'b0, !OVF_EN, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 5'd10);
    checkOvf("addOvf", 1'b1);
    applyStimulus(3'b110, 32'h80000000, 32'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd11);
    checkOutput("subOvf", 32'h7FFFFFFF, 1'b0, !OVF_EN, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 5'd11);
    checkOvf("subOvf", 1'b1);
    applyStimulus(3'b010, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd12);
    checkOutput("ovfInvalid", 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd12);
    checkOvf("ovfInvalid", 1'b0);

    // Mid-stream reset discards the in-flight instruction
    applyStimulus(3'b010, 32'd2, 32'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h9, 5'd13);
    checkOutput("preRst", 32'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h9, 5'd13);
    rst = 1'b1;
    applyStimulus(3'b110, 32'd4, 32'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h9, 5'd13);
    checkOutput("midRst", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
